// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_arb_pkg
// Purpose  : Types and constants shared by the memory bus arbiter, its port
//            interface and its winner-select sub-module.
// Contents : c_DATA_W  - data/address width (32)
//            c_BURST_W - burst counter width (4)
//            arb_state_e - arbiter FSM state encoding
//            port_idx_t  - requester index (0 or 1)
//            sat_inc()   - saturating increment for the burst counter
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  localparam int unsigned c_DATA_W  = 32;
  localparam int unsigned c_BURST_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  typedef logic port_idx_t;

  function automatic logic [c_BURST_W-1:0] sat_inc(input logic [c_BURST_W-1:0] v);
    return (v == {c_BURST_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : mem_bus_arbiter_if
// Purpose   : Bundles the two requester ports and the shared memory/GPIO bus
//             of the arbiter. Signal names are seen from the arbiter side.
// Modports  : slave  - the arbiter (consumes requests, drives acks and bus)
//             master - the requesters plus bus memory model
// Revision  : 1.0 - initial release
// ============================================================================
interface mem_bus_arbiter_if;
  import mem_arb_pkg::*;

  // Requester port 0
  logic                i_Req0;
  logic                i_WE0;
  logic [c_DATA_W-1:0] i_A0;
  logic [c_DATA_W-1:0] i_D0;
  logic                o_Ack0;
  logic [c_DATA_W-1:0] o_D0;
  // Requester port 1
  logic                i_Req1;
  logic                i_WE1;
  logic [c_DATA_W-1:0] i_A1;
  logic [c_DATA_W-1:0] i_D1;
  logic                o_Ack1;
  logic [c_DATA_W-1:0] o_D1;
  // Shared bus and status
  logic [c_DATA_W-1:0] o_MA;
  logic                o_MWE;
  logic [c_DATA_W-1:0] o_MD;
  logic [c_DATA_W-1:0] i_MQ;
  logic                o_Busy;
  logic                o_Owner;

  modport slave (
    input  i_Req0, i_WE0, i_A0, i_D0, i_Req1, i_WE1, i_A1, i_D1, i_MQ,
    output o_Ack0, o_D0, o_Ack1, o_D1, o_MA, o_MWE, o_MD, o_Busy, o_Owner
  );

  modport master (
    output i_Req0, i_WE0, i_A0, i_D0, i_Req1, i_WE1, i_A1, i_D1, i_MQ,
    input  o_Ack0, o_D0, o_Ack1, o_D1, o_MA, o_MWE, o_MD, o_Busy, o_Owner
  );

endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pick
// Purpose  : Combinational winner select between two requesters.
// Ports    : i_req0/i_req1 - pending requests
//            i_last        - port served last
//            i_burst       - consecutive grants to i_last (0 = none yet)
//            o_valid       - at least one request pending
//            o_winner      - selected port
// Config   : MEM_ARB_ROUND_ROBIN_EN defined   -> burst-capped alternation
//            MEM_ARB_ROUND_ROBIN_EN undefined -> fixed priority, port 0 first
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  wire logic                 i_req0,
  input  wire logic                 i_req1,
  input  wire logic                 i_last,
  input  wire logic [c_BURST_W-1:0] i_burst,
  output logic                      o_valid,
  output logic                      o_winner
);

  localparam logic [c_BURST_W-1:0] c_MAX_BURST = 4'(MAX_BURST);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    o_valid  = i_req0 | i_req1;
    o_winner = 1'b0;
    if (i_req0 && i_req1) begin
      // A zero burst count means nobody has been served since reset, so the
      // reset owner index does not count as "served last" and port 0 wins.
      if ((i_burst != '0) && (i_burst < c_MAX_BURST)) begin
        o_winner = i_last;
      end else begin
        o_winner = ~i_last;
      end
    end else if (i_req1) begin
      o_winner = 1'b1;
    end
  end
`else
  always_comb begin
    o_valid  = i_req0 | i_req1;
    o_winner = ~i_req0 & i_req1;
  end

  // History inputs only matter for the round-robin build.
  logic w_unused;
  assign w_unused = ^{i_last, i_burst, c_MAX_BURST};
`endif

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Two-port arbiter onto a single data-memory/GPIO bus. Each
//            transaction takes three cycles: IDLE (arbitrate and latch),
//            ACCESS (drive bus, capture read data), RESP (one-cycle ack).
// Ports    : Clk   - clock, rising edge
//            Reset - asynchronous, active-low
//            bus   - mem_bus_arbiter_if.slave: requester ports 0/1, shared
//                    bus (o_MA/o_MWE/o_MD/i_MQ), o_Busy, o_Owner
// Params   : MAX_BURST - consecutive grants to one port while the other is
//                        waiting (1..15, round-robin build only)
// Config   : MEM_ARB_ROUND_ROBIN_EN selects round-robin with burst cap;
//            undefined gives fixed priority to port 0.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  wire logic        Clk,
  input  wire logic        Reset,
  mem_bus_arbiter_if.slave bus
);

  arb_state_e           state_q, state_d;
  port_idx_t            owner_q, owner_d;
  logic [c_BURST_W-1:0] burst_q, burst_d;
  logic                 we_q,    we_d;
  logic [c_DATA_W-1:0]  ma_q,    ma_d;
  logic [c_DATA_W-1:0]  md_q,    md_d;
  logic [c_DATA_W-1:0]  d0_q,    d0_d;
  logic [c_DATA_W-1:0]  d1_q,    d1_d;
  logic                 mwe_q,   mwe_d;
  logic                 ack0_q,  ack0_d;
  logic                 ack1_q,  ack1_d;
  logic                 busy_q,  busy_d;

  logic                 w_valid;
  logic                 w_winner;
  logic                 w_sel_we;
  logic [c_DATA_W-1:0]  w_sel_a;
  logic [c_DATA_W-1:0]  w_sel_d;

  mem_arb_pick #(
    .MAX_BURST (MAX_BURST)
  ) u_pick (
    .i_req0   (bus.i_Req0),
    .i_req1   (bus.i_Req1),
    .i_last   (owner_q),
    .i_burst  (burst_q),
    .o_valid  (w_valid),
    .o_winner (w_winner)
  );

  assign w_sel_we = w_winner ? bus.i_WE1 : bus.i_WE0;
  assign w_sel_a  = w_winner ? bus.i_A1  : bus.i_A0;
  assign w_sel_d  = w_winner ? bus.i_D1  : bus.i_D0;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    burst_d = burst_q;
    we_d    = we_q;
    ma_d    = ma_q;
    md_d    = md_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    busy_d  = busy_q;
    mwe_d   = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (w_valid) begin
          state_d = ST_ACCESS;
          owner_d = w_winner;
          burst_d = (w_winner == owner_q) ? sat_inc(burst_q) : 4'd1;
          we_d    = w_sel_we;
          ma_d    = w_sel_a;
          md_d    = w_sel_d;
          // Write strobe is registered so it is high for exactly the ACCESS cycle.
          mwe_d   = w_sel_we;
          busy_d  = 1'b1;
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        // i_MQ is combinational from o_MA, so it is valid here on reads.
        if (owner_q) begin
          ack1_d = 1'b1;
          d1_d   = we_q ? '0 : bus.i_MQ;
        end else begin
          ack0_d = 1'b1;
          d0_d   = we_q ? '0 : bus.i_MQ;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b1;
      burst_q <= '0;
      we_q    <= 1'b0;
      ma_q    <= '0;
      md_q    <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
      mwe_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
      we_q    <= we_d;
      ma_q    <= ma_d;
      md_q    <= md_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      mwe_q   <= mwe_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_MA    = ma_q;
  assign bus.o_MD    = md_q;
  assign bus.o_MWE   = mwe_q;
  assign bus.o_Ack0  = ack0_q;
  assign bus.o_Ack1  = ack1_q;
  assign bus.o_D0    = d0_q;
  assign bus.o_D1    = d1_q;
  assign bus.o_Busy  = busy_q;
  assign bus.o_Owner = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Directed self-checking bench for mem_bus_arbiter. A small word
//            memory on the shared bus answers reads combinationally and
//            takes writes on the clock edge while o_MWE is high.
// Config   : expected grant order follows MEM_ARB_ROUND_ROBIN_EN
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 Clk = ~Clk;

  mem_bus_arbiter_if bus_if ();

  mem_bus_arbiter #(
    .MAX_BURST (4)
  ) u_dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_if)
  );

  logic [31:0] mem [0:63];
  assign bus_if.i_MQ = mem[bus_if.o_MA[5:0]];
  always @(posedge Clk) begin
    if (bus_if.o_MWE) mem[bus_if.o_MA[5:0]] <= bus_if.o_MD;
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"},  {31'd0, bus_if.o_Busy},  32'd0);
    chk({tag, "_owner"}, {31'd0, bus_if.o_Owner}, 32'd1);
    chk({tag, "_mwe"},   {31'd0, bus_if.o_MWE},   32'd0);
    chk({tag, "_acks"},  {30'd0, bus_if.o_Ack1, bus_if.o_Ack0}, 32'd0);
    chk({tag, "_d0"},    bus_if.o_D0, 32'd0);
    chk({tag, "_d1"},    bus_if.o_D1, 32'd0);
    chk({tag, "_ma"},    bus_if.o_MA, 32'd0);
    chk({tag, "_md"},    bus_if.o_MD, 32'd0);
  endtask

  logic [7:0]  exp_order;
  logic [31:0] exp_d0;
  logic [31:0] exp_d1;

  initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_order = 8'b1111_0000;   // bit k = owner of grant k: 0,0,0,0,1,1,1,1
`else
    exp_order = 8'b0000_0000;   // port 0 always wins
`endif
    Reset = 1'b0;
    bus_if.i_Req0 = 1'b0; bus_if.i_WE0 = 1'b0; bus_if.i_A0 = '0; bus_if.i_D0 = '0;
    bus_if.i_Req1 = 1'b0; bus_if.i_WE1 = 1'b0; bus_if.i_A1 = '0; bus_if.i_D1 = '0;

    // Reset state
    tick;
    chk_reset_state("rst");
    tick;
    Reset = 1'b1;

    // Port 0 write DEADBEEF to A=5
    bus_if.i_Req0 = 1'b1; bus_if.i_WE0 = 1'b1; bus_if.i_A0 = 32'd5; bus_if.i_D0 = 32'hDEADBEEF;
    tick;  // ACCESS
    chk("wr0_mwe",   {31'd0, bus_if.o_MWE}, 32'd1);
    chk("wr0_ma",    bus_if.o_MA, 32'd5);
    chk("wr0_md",    bus_if.o_MD, 32'hDEADBEEF);
    chk("wr0_busy",  {31'd0, bus_if.o_Busy}, 32'd1);
    chk("wr0_owner", {31'd0, bus_if.o_Owner}, 32'd0);
    chk("wr0_noack", {30'd0, bus_if.o_Ack1, bus_if.o_Ack0}, 32'd0);
    tick;  // RESP
    chk("wr0_ack",   {30'd0, bus_if.o_Ack1, bus_if.o_Ack0}, 32'd1);
    chk("wr0_mwe_off", {31'd0, bus_if.o_MWE}, 32'd0);
    chk("wr0_d0",    bus_if.o_D0, 32'd0);
    bus_if.i_Req0 = 1'b0;
    tick;  // IDLE
    chk("wr0_ack_off", {30'd0, bus_if.o_Ack1, bus_if.o_Ack0}, 32'd0);
    chk("wr0_idle_busy", {31'd0, bus_if.o_Busy}, 32'd0);

    // Port 1 read A=5
    bus_if.i_Req1 = 1'b1; bus_if.i_WE1 = 1'b0; bus_if.i_A1 = 32'd5;
    tick;  // ACCESS
    chk("rd1_mwe",   {31'd0, bus_if.o_MWE}, 32'd0);
    chk("rd1_ma",    bus_if.o_MA, 32'd5);
    chk("rd1_owner", {31'd0, bus_if.o_Owner}, 32'd1);
    tick;  // RESP
    chk("rd1_ack",   {30'd0, bus_if.o_Ack1, bus_if.o_Ack0}, 32'd2);
    chk("rd1_d1",    bus_if.o_D1, 32'hDEADBEEF);
    chk("rd1_d0",    bus_if.o_D0, 32'd0);
    bus_if.i_Req1 = 1'b0;
    tick;  // IDLE

    // Port 0 read A=5, then write A=32 (GPIO region) which must zero o_D0
    bus_if.i_Req0 = 1'b1; bus_if.i_WE0 = 1'b0; bus_if.i_A0 = 32'd5;
    tick; tick;  // RESP
    chk("rd0_ack", {30'd0, bus_if.o_Ack1, bus_if.o_Ack0}, 32'd1);
    chk("rd0_d0",  bus_if.o_D0, 32'hDEADBEEF);
    bus_if.i_WE0 = 1'b1; bus_if.i_A0 = 32'd32; bus_if.i_D0 = 32'h12345678;
    tick;  // IDLE: held request is a new transaction
    chk("gp_idle_mwe", {31'd0, bus_if.o_MWE}, 32'd0);
    tick;  // ACCESS
    chk("gp_mwe", {31'd0, bus_if.o_MWE}, 32'd1);
    chk("gp_ma",  bus_if.o_MA, 32'd32);
    tick;  // RESP
    chk("gp_ack", {30'd0, bus_if.o_Ack1, bus_if.o_Ack0}, 32'd1);
    chk("gp_d0",  bus_if.o_D0, 32'd0);
    chk("gp_d1",  bus_if.o_D1, 32'hDEADBEEF);
    bus_if.i_Req0 = 1'b0;
    tick;  // IDLE: bus holds the latched address, strobe low
    chk("hold_ma",  bus_if.o_MA, 32'd32);
    chk("hold_md",  bus_if.o_MD, 32'h12345678);
    chk("hold_mwe", {31'd0, bus_if.o_MWE}, 32'd0);

    // Reset, then both ports request continuously (reads of A=5 and A=32)
    Reset = 1'b0;
    #1;
    chk_reset_state("rst2");
    bus_if.i_Req0 = 1'b1; bus_if.i_WE0 = 1'b0; bus_if.i_A0 = 32'd5;
    bus_if.i_Req1 = 1'b1; bus_if.i_WE1 = 1'b0; bus_if.i_A1 = 32'd32;
    tick;
    Reset = 1'b1;
    exp_d0 = 32'd0;
    exp_d1 = 32'd0;
    for (int k = 0; k < 8; k++) begin
      tick;  // ACCESS
      chk($sformatf("arb%0d_owner", k), {31'd0, bus_if.o_Owner}, {31'd0, exp_order[k]});
      tick;  // RESP
      if (exp_order[k]) exp_d1 = 32'h12345678;
      else              exp_d0 = 32'hDEADBEEF;
      chk($sformatf("arb%0d_ack", k), {30'd0, bus_if.o_Ack1, bus_if.o_Ack0},
          exp_order[k] ? 32'd2 : 32'd1);
      chk($sformatf("arb%0d_d0", k), bus_if.o_D0, exp_d0);
      chk($sformatf("arb%0d_d1", k), bus_if.o_D1, exp_d1);
      tick;  // IDLE
    end
    bus_if.i_Req0 = 1'b0;
    bus_if.i_Req1 = 1'b0;
    tick;

    // Reset during RESP aborts; held request is re-served afterwards
    bus_if.i_Req1 = 1'b1; bus_if.i_WE1 = 1'b0; bus_if.i_A1 = 32'd5;
    tick; tick;  // RESP
    Reset = 1'b0;
    #1;
    chk_reset_state("rst_resp");
    tick;
    chk("rst_hold_ack", {30'd0, bus_if.o_Ack1, bus_if.o_Ack0}, 32'd0);
    Reset = 1'b1;
    tick;  // ACCESS
    chk("rerun_owner", {31'd0, bus_if.o_Owner}, 32'd1);
    chk("rerun_ma",    bus_if.o_MA, 32'd5);
    chk("rerun_noack", {30'd0, bus_if.o_Ack1, bus_if.o_Ack0}, 32'd0);
    tick;  // RESP
    chk("rerun_ack",   {30'd0, bus_if.o_Ack1, bus_if.o_Ack0}, 32'd2);
    chk("rerun_d1",    bus_if.o_D1, 32'hDEADBEEF);
    chk("rerun_d0",    bus_if.o_D0, 32'd0);
    bus_if.i_Req1 = 1'b0;
    tick;
    chk("final_busy",  {31'd0, bus_if.o_Busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter: MAX_BURST, 4, max consecutive grants to one port while the other port is requesting; legal range 1..15.
REQ-002 Port: Clk  in  1  single clock; all state updates on posedge.
REQ-003 Port: Reset  in  1  asynchronous, active-low reset.
REQ-004 Port: i_Req0 / i_Req1  in  1  port request; held high with stable i_WEn/i_An/i_Dn until o_Ackn.
REQ-005 Port: i_WE0 / i_WE1  in  1  1 = write, 0 = read.
REQ-006 Port: i_A0 / i_A1  in  32  word address.
REQ-007 Port: i_D0 / i_D1  in  32  write data.
REQ-008 Port: o_Ack0 / o_Ack1  out  1  one-cycle completion pulse.
REQ-009 Port: o_D0 / o_D1  out  32  read data, valid from o_Ackn onward.
REQ-010 Port: o_MA  out  32  address to data-memory/GPIO bus.
REQ-011 Port: o_MWE  out  1  bus write enable.
REQ-012 Port: o_MD  out  32  bus write data.
REQ-013 Port: i_MQ  in  32  bus read data, combinational from o_MA when o_MWE low.
REQ-014 Port: o_Busy  out  1  high in ACCESS and RESP.
REQ-015 Port: o_Owner  out  1  index of port currently or last served.

Function
REQ-016 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when any request is pending; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-017 IDLE: select winner, latch its WE/A/D, set o_Owner, update burst counter.
REQ-018 Winner selection: single request wins; with both pending, owner wins if it was served last and burst count < MAX_BURST, otherwise the other port wins.
REQ-019 Burst counter: saturating 4 bits; increments when the last-served port is re-granted, reset to 1 when ownership changes.
REQ-020 ACCESS: o_MA/o_MD driven from latch; o_MWE high for exactly this one cycle on writes, never otherwise; i_MQ captured into the owner's read register at the end of ACCESS on reads.
REQ-021 RESP: owner's o_Ackn high for exactly one cycle; writes load o_Dn with 32'h0.
REQ-022 Latency: request seen in IDLE at cycle t -> o_Ackn at t+2; throughput one access per 3 cycles.
REQ-023 A request high in the IDLE cycle after its ack is a new transaction.
REQ-024 o_Dn holds its value until that port's next ack; the non-owner's o_D is never modified.
REQ-025 Requests arriving in ACCESS/RESP wait; no request is dropped.
REQ-026 Outside ACCESS, o_MA/o_MD hold latched values and o_MWE = 0.

Reset
REQ-027 Reset low asynchronously forces IDLE, o_MWE = 0, o_Ack0/1 = 0, o_D0/1 = 0, o_MA/o_MD = 0, o_Busy = 0, o_Owner = 1, burst count = 0.
REQ-028 Reset asserted during ACCESS or RESP aborts the transaction: no ack is issued, and any write completed before the reset edge is not rolled back.

Configuration
REQ-029 Macro MEM_ARB_ROUND_ROBIN_EN defined: arbitration per REQ-018 with MAX_BURST cap.
REQ-030 Macro undefined: fixed priority, port 0 always wins when both request, MAX_BURST and the burst counter are unused, port 1 may starve.

Structure
REQ-031 Shared package mem_arb_pkg holds the FSM state typedef, the port-index typedef and the 32-bit width constant.
REQ-032 One sub-module, mem_arb_pick: combinational winner select from requests, last owner and burst count, with behaviour per REQ-018/REQ-030.

Verification
REQ-033 Port 0 writes 32'hDEADBEEF to A=5 -> o_MWE high one cycle with o_MA=5; o_Ack0 at t+2; o_D0=0.
REQ-034 Port 1 reads A=5 after REQ-033 -> o_Ack1 at t+2, o_D1=32'hDEADBEEF; o_D0 unchanged.
REQ-035 Both ports request continuously, MAX_BURST=4, round-robin on -> grant order 0,0,0,0,1,1,1,1,0...; without macro all grants go to port 0.
REQ-036 Simultaneous first request after reset -> port 0 served first (o_Owner reset = 1).
REQ-037 Reset pulsed during RESP -> no ack, state IDLE, all outputs zero; a held request is re-served after reset release.
REQ-038 Write to A=32 (GPIO region) -> o_MA=32, o_MWE one cycle, ack at t+2 (arbiter is address-agnostic).
